// File: rtl/dram_lsu.sv
// dram_lsu: byte-addressed RV32 load/store initiator driving a word-addressed DRAM port (a/we/d/spo).
// Latency: accept to resp_valid = 2 edges aligned, 3 edges word-crossing split, 1 edge on error.
// Backpressure: req_ready only in IDLE; the response is held in RESP until resp_ready.
// Option DRAM_LSU_MISALIGN_SPLIT_EN: word-crossing accesses are split into LO+HI words;
// without it a word-crossing access is answered with resp_err and the DRAM is never written.
module dram_lsu #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_op,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_BITS-1:0] a,
    output logic [3:0]           we,
    output logic [31:0]          d,
    input  logic [31:0]          spo
);

`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, RESP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, RESP = 2'd3} state_t;
`endif

    state_t               state_q, state_d;
    logic [2:0]           op_q, op_d;
    logic                 write_q, write_d;
    logic [1:0]           off_q, off_d;
    logic [ADDR_BITS-1:0] a_q, a_d;
    logic [3:0]           we_q, we_d;
    logic [31:0]          d_q, d_d;
    logic [31:0]          rdata_q, rdata_d;
    logic                 err_q, err_d;
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
    logic                 cross_q, cross_d;
    logic [3:0]           we_hi_q, we_hi_d;
    logic [31:0]          d_hi_q, d_hi_d;
    logic [31:0]          lo_word_q, lo_word_d;
`endif

    logic [3:0]  size_mask;
    logic [3:0]  size_bytes;
    logic [3:0]  end_byte;
    logic        crossing;
    logic        op_ok;
    logic        acc_err;
    logic [3:0]  we_lo_in;
    logic [31:0] d_lo_in;
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
    logic [7:0]  mask8;
    logic [63:0] sdata;
    logic [3:0]  we_hi_in;
    logic [31:0] d_hi_in;
`endif
    logic [63:0] rd_pair;
    logic [31:0] rd_ext;

    // Shift the word pair down to the access offset, then extend per funct3.
    function automatic logic [31:0] load_extract(input logic [63:0] pair, input logic [1:0] off,
                                                 input logic [2:0] op);
        logic [31:0] r;
        r = 32'(pair >> {off, 3'b000});
        case (op)
            3'b000:  return {{24{r[7]}}, r[7:0]};
            3'b100:  return {24'h0, r[7:0]};
            3'b001:  return {{16{r[15]}}, r[15:0]};
            3'b101:  return {16'h0, r[15:0]};
            default: return r;
        endcase
    endfunction

    // Decode the incoming request: size, legality, crossing and store byte lanes.
    always_comb begin
        case (req_op[1:0])
            2'b00:   begin size_mask = 4'b0001; size_bytes = 4'd1; end
            2'b01:   begin size_mask = 4'b0011; size_bytes = 4'd2; end
            default: begin size_mask = 4'b1111; size_bytes = 4'd4; end
        endcase
        op_ok    = (req_op == 3'b000) || (req_op == 3'b001) || (req_op == 3'b010) ||
                   (req_op == 3'b100) || (req_op == 3'b101);
        end_byte = {2'b00, req_addr[1:0]} + size_bytes;
        crossing = end_byte > 4'd4;
        acc_err  = !op_ok || (req_write && req_op[2]) || (|req_addr[31:ADDR_BITS+2]);
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
        sdata    = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
        mask8    = {4'h0, size_mask} << req_addr[1:0];
        we_lo_in = mask8[3:0];
        d_lo_in  = sdata[31:0];
        we_hi_in = mask8[7:4];
        d_hi_in  = sdata[63:32];
`else
        // Without splitting, a crossing access never reaches the DRAM, so 4-bit lanes suffice.
        acc_err  = acc_err || crossing;
        we_lo_in = size_mask << req_addr[1:0];
        d_lo_in  = req_wdata << {req_addr[1:0], 3'b000};
`endif
    end

    // Assemble read data: in HI the upper word is live on spo and the lower was captured in LO.
    always_comb begin
        rd_pair = {32'h0, spo};
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
        if (state_q == HI) rd_pair = {spo, lo_word_q};
`endif
        rd_ext = load_extract(rd_pair, off_q, op_q);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = acc_err ? RESP : LO;
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
            LO:   state_d = cross_q ? HI : RESP;
            HI:   state_d = RESP;
`else
            LO:   state_d = RESP;
`endif
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
    end

    // Datapath next values: DRAM port drive, captured request fields and the response.
    always_comb begin
        op_d    = op_q;
        write_d = write_q;
        off_d   = off_q;
        a_d     = a_q;
        we_d    = we_q;
        d_d     = d_q;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
        cross_d   = cross_q;
        we_hi_d   = we_hi_q;
        d_hi_d    = d_hi_q;
        lo_word_d = lo_word_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    write_d = req_write;
                    off_d   = req_addr[1:0];
                    err_d   = acc_err;
                    rdata_d = 32'h0;
                    // An erroring request leaves the DRAM port untouched (we stays 0).
                    if (!acc_err) begin
                        a_d  = req_addr[ADDR_BITS+1:2];
                        we_d = req_write ? we_lo_in : 4'h0;
                        d_d  = d_lo_in;
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
                        cross_d = crossing;
                        we_hi_d = req_write ? we_hi_in : 4'h0;
                        d_hi_d  = d_hi_in;
`endif
                    end
                end
            end
            LO: begin
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
                lo_word_d = spo;
                if (cross_q) begin
                    // Next word, wrapping at the top of the address space.
                    a_d  = a_q + ADDR_BITS'(1);
                    we_d = we_hi_q;
                    d_d  = d_hi_q;
                end else begin
                    we_d    = 4'h0;
                    rdata_d = write_q ? 32'h0 : rd_ext;
                end
`else
                we_d    = 4'h0;
                rdata_d = write_q ? 32'h0 : rd_ext;
`endif
            end
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
            HI: begin
                we_d    = 4'h0;
                rdata_d = write_q ? 32'h0 : rd_ext;
            end
`endif
            default: ;
        endcase
    end

    // Datapath registers; reset drops we immediately so an interrupted store writes nothing more.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= 3'h0;
            write_q <= 1'b0;
            off_q   <= 2'h0;
            a_q     <= '0;
            we_q    <= 4'h0;
            d_q     <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
            cross_q   <= 1'b0;
            we_hi_q   <= 4'h0;
            d_hi_q    <= 32'h0;
            lo_word_q <= 32'h0;
`endif
        end else begin
            op_q    <= op_d;
            write_q <= write_d;
            off_q   <= off_d;
            a_q     <= a_d;
            we_q    <= we_d;
            d_q     <= d_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
            cross_q   <= cross_d;
            we_hi_q   <= we_hi_d;
            d_hi_q    <= d_hi_d;
            lo_word_q <= lo_word_d;
`endif
        end
    end

    assign a          = a_q;
    assign we         = we_q;
    assign d          = d_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dram_lsu.sv
// tb_dram_lsu: directed tests of dram_lsu against a behavioural word DRAM.
// Latency: n/a (bench).
// Backpressure: resp_ready is held low by default and raised only to retire a response.
module tb_dram_lsu;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [15:0] a;
    logic [3:0]  we;
    logic [31:0] d;
    logic [31:0] spo;

    int n_chk;
    int n_fail;

    logic [31:0] mem [0:65535];

    logic [2:0]  sub_op   [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
    logic [31:0] sub_addr [5] = '{32'h9, 32'h9, 32'hA, 32'hA, 32'h9};
    logic [31:0] sub_exp  [5] = '{32'hFFFFFFBE, 32'h000000BE, 32'hFFFFDEAD, 32'h0000DEAD, 32'hFFFFADBE};

    dram_lsu #(.ADDR_BITS(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .a(a), .we(we), .d(d), .spo(spo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural DRAM: combinational read, byte-enabled write on the rising edge.
    assign spo = mem[a];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[a][8*i +: 8] <= d[8*i +: 8];
    end

    task automatic issue(input logic wr, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int start, output int edges, output logic [3:0] we_or);
        edges = start;
        we_or = we;
        while (!resp_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            we_or = we_or | we;
        end
    endtask

    task automatic finish_resp();
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic store_word(input logic [31:0] addr, input logic [31:0] wd);
        int e;
        logic [3:0] w;
        issue(1'b1, 3'b010, addr, wd);
        wait_resp(1, e, w);
        finish_resp();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got %b want 1", req_ready); end
        n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", resp_valid); end
        n_chk++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata got %h want 0", resp_rdata); end
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got %b want 0", resp_err); end
        n_chk++; if (a !== 16'h0) begin n_fail++; $display("FAIL rst_a got %h want 0", a); end
        n_chk++; if (we !== 4'h0) begin n_fail++; $display("FAIL rst_we got %h want 0", we); end
        n_chk++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_d got %h want 0", d); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_store_word();
        int e;
        logic [3:0] w;
        issue(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
        n_chk++; if (a !== 16'h0002) begin n_fail++; $display("FAIL sw_a got %h want 0002", a); end
        n_chk++; if (we !== 4'b1111) begin n_fail++; $display("FAIL sw_we got %b want 1111", we); end
        n_chk++; if (d !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_d got %h want deadbeef", d); end
        n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL sw_busy got %b want 0", req_ready); end
        wait_resp(1, e, w);
        n_chk++; if (e !== 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", e); end
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL sw_err got %b want 0", resp_err); end
        n_chk++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rdata got %h want 0", resp_rdata); end
        n_chk++; if (we !== 4'h0) begin n_fail++; $display("FAIL sw_we_off got %b want 0", we); end
        n_chk++; if (mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_mem got %h want deadbeef", mem[2]); end
        finish_resp();
    endtask

    task automatic test_load_word_hold();
        int e;
        logic [3:0] w;
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        wait_resp(1, e, w);
        n_chk++; if (e !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", e); end
        n_chk++; if (w !== 4'h0) begin n_fail++; $display("FAIL lw_we got %b want 0", w); end
        n_chk++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata got %h want deadbeef", resp_rdata); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_chk++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid[%0d] got %b want 1", c, resp_valid); end
            n_chk++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_rdata[%0d] got %h want deadbeef", c, resp_rdata); end
            n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL hold_err[%0d] got %b want 0", c, resp_err); end
            n_chk++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL hold_ready[%0d] got %b want 0", c, req_ready); end
        end
        finish_resp();
        n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL retire_valid got %b want 0", resp_valid); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL retire_ready got %b want 1", req_ready); end
    endtask

    task automatic test_load_sub();
        int e;
        logic [3:0] w;
        for (int k = 0; k < 5; k++) begin
            issue(1'b0, sub_op[k], sub_addr[k], 32'h0);
            wait_resp(1, e, w);
            n_chk++; if (e !== 2) begin n_fail++; $display("FAIL sub_latency[%0d] got %0d want 2", k, e); end
            n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL sub_err[%0d] got %b want 0", k, resp_err); end
            n_chk++; if (resp_rdata !== sub_exp[k]) begin n_fail++; $display("FAIL sub_rdata[%0d] got %h want %h", k, resp_rdata, sub_exp[k]); end
            finish_resp();
        end
    endtask

    task automatic test_misalign();
        int e;
        logic [3:0] w;
        issue(1'b1, 3'b001, 32'hB, 32'h00001234);
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
        n_chk++; if (a !== 16'h0002) begin n_fail++; $display("FAIL sh_lo_a got %h want 0002", a); end
        n_chk++; if (we !== 4'b1000) begin n_fail++; $display("FAIL sh_lo_we got %b want 1000", we); end
        n_chk++; if (d[31:24] !== 8'h34) begin n_fail++; $display("FAIL sh_lo_d got %h want 34", d[31:24]); end
        @(posedge clk); #1;
        n_chk++; if (a !== 16'h0003) begin n_fail++; $display("FAIL sh_hi_a got %h want 0003", a); end
        n_chk++; if (we !== 4'b0001) begin n_fail++; $display("FAIL sh_hi_we got %b want 0001", we); end
        n_chk++; if (d[7:0] !== 8'h12) begin n_fail++; $display("FAIL sh_hi_d got %h want 12", d[7:0]); end
        wait_resp(2, e, w);
        n_chk++; if (e !== 3) begin n_fail++; $display("FAIL sh_latency got %0d want 3", e); end
        n_chk++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL sh_err got %b want 0", resp_err); end
        n_chk++; if (mem[2] !== 32'h34ADBEEF) begin n_fail++; $display("FAIL sh_mem2 got %h want 34adbeef", mem[2]); end
        n_chk++; if (mem[3][7:0] !== 8'h12) begin n_fail++; $display("FAIL sh_mem3 got %h want 12", mem[3][7:0]); end
        finish_resp();
        issue(1'b0, 3'b101, 32'hB, 32'h0);
        wait_resp(1, e, w);
        n_chk++; if (e !== 3) begin n_fail++; $display("FAIL lhu_latency got %0d want 3", e); end
        n_chk++; if (resp_rdata !== 32'h00001234) begin n_fail++; $display("FAIL lhu_rdata got %h want 00001234", resp_rdata); end
        finish_resp();
`else
        wait_resp(1, e, w);
        n_chk++; if (e !== 1) begin n_fail++; $display("FAIL sh_latency got %0d want 1", e); end
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL sh_err got %b want 1", resp_err); end
        n_chk++; if (w !== 4'h0) begin n_fail++; $display("FAIL sh_we got %b want 0", w); end
        n_chk++; if (mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sh_mem2 got %h want deadbeef", mem[2]); end
        finish_resp();
`endif
    endtask

    task automatic test_errors();
        int e;
        logic [3:0] w;
        issue(1'b0, 3'b010, 32'h00040000, 32'h0);
        wait_resp(1, e, w);
        n_chk++; if (e !== 1) begin n_fail++; $display("FAIL oor_latency got %0d want 1", e); end
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL oor_err got %b want 1", resp_err); end
        n_chk++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL oor_rdata got %h want 0", resp_rdata); end
        n_chk++; if (w !== 4'h0) begin n_fail++; $display("FAIL oor_we got %b want 0", w); end
        finish_resp();
        issue(1'b0, 3'b011, 32'h0, 32'h0);
        wait_resp(1, e, w);
        n_chk++; if (e !== 1) begin n_fail++; $display("FAIL badop_latency got %0d want 1", e); end
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL badop_err got %b want 1", resp_err); end
        finish_resp();
        issue(1'b1, 3'b100, 32'h10, 32'hFF);
        wait_resp(1, e, w);
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL sbu_err got %b want 1", resp_err); end
        n_chk++; if (w !== 4'h0) begin n_fail++; $display("FAIL sbu_we got %b want 0", w); end
        finish_resp();
    endtask

    task automatic test_wrap();
        int e;
        logic [3:0] w;
        store_word(32'h0003FFFC, 32'h11223344);
        store_word(32'h00000000, 32'hAABBCCDD);
        n_chk++; if (mem[16'hFFFF] !== 32'h11223344) begin n_fail++; $display("FAIL top_mem got %h want 11223344", mem[16'hFFFF]); end
        issue(1'b0, 3'b010, 32'h0003FFFD, 32'h0);
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
        n_chk++; if (a !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_lo_a got %h want ffff", a); end
        @(posedge clk); #1;
        n_chk++; if (a !== 16'h0000) begin n_fail++; $display("FAIL wrap_hi_a got %h want 0000", a); end
        wait_resp(2, e, w);
        n_chk++; if (e !== 3) begin n_fail++; $display("FAIL wrap_latency got %0d want 3", e); end
        n_chk++; if (resp_rdata !== 32'hDD112233) begin n_fail++; $display("FAIL wrap_rdata got %h want dd112233", resp_rdata); end
`else
        wait_resp(1, e, w);
        n_chk++; if (resp_err !== 1'b1) begin n_fail++; $display("FAIL wrap_err got %b want 1", resp_err); end
        n_chk++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL wrap_rdata got %h want 0", resp_rdata); end
`endif
        finish_resp();
    endtask

    task automatic test_reset_mid();
        int e;
        logic [3:0] w;
        store_word(32'hC, 32'hCAFEF00D);
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
        issue(1'b1, 3'b001, 32'hB, 32'h0000ABCD);
        @(posedge clk); #1;
        n_chk++; if (we !== 4'b0001) begin n_fail++; $display("FAIL mid_hi_we got %b want 0001", we); end
`else
        issue(1'b1, 3'b010, 32'h8, 32'h01020304);
        n_chk++; if (we !== 4'b1111) begin n_fail++; $display("FAIL mid_lo_we got %b want 1111", we); end
`endif
        rst_n = 1'b0;
        #1;
        n_chk++; if (we !== 4'h0) begin n_fail++; $display("FAIL mid_we got %b want 0", we); end
        n_chk++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b want 1", req_ready); end
        n_chk++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", resp_valid); end
        @(posedge clk); #1;
        n_chk++; if (mem[3] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL mid_mem3 got %h want cafef00d", mem[3]); end
`ifdef DRAM_LSU_MISALIGN_SPLIT_EN
        n_chk++; if (mem[2][31:24] !== 8'hCD) begin n_fail++; $display("FAIL mid_lo_kept got %h want cd", mem[2][31:24]); end
`else
        n_chk++; if (mem[2] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mid_mem2 got %h want deadbeef", mem[2]); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        issue(1'b0, 3'b010, 32'hC, 32'h0);
        wait_resp(1, e, w);
        n_chk++; if (resp_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL post_rst_rdata got %h want cafef00d", resp_rdata); end
        finish_resp();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_op = 3'b000;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        resp_ready = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_store_word();
        test_load_word_hold();
        test_load_sub();
        test_misalign();
        test_errors();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
